// File: rtl/div_ctrl.sv
// Iterative restoring divider (DIV/DIVU) with its sequencing FSM for the EX stage.
// Produces {remainder, quotient} after WIDTH iterations plus one finalise cycle.
module div_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic               clk,
    input  logic               Rst_n,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH:0]   dvd;
    logic [WIDTH-1:0]   dvr;
    logic               sgn;
    logic               sign1;
    logic               sign2;

    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;

    always_comb begin
        abs1  = (signed_div_i && opdata1_i[WIDTH-1]) ? ('0 - opdata1_i) : opdata1_i;
        abs2  = (signed_div_i && opdata2_i[WIDTH-1]) ? ('0 - opdata2_i) : opdata2_i;
        diff  = {1'b0, dvd[2*WIDTH-1:WIDTH]} - {1'b0, dvr};
        // Quotient sign follows the operand signs; remainder takes the dividend's sign.
        q_fix = (sgn && (sign1 != sign2)) ? ('0 - dvd[WIDTH-1:0]) : dvd[WIDTH-1:0];
        r_fix = (sgn && sign1) ? ('0 - dvd[2*WIDTH:WIDTH+1]) : dvd[2*WIDTH:WIDTH+1];
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= S_FREE;
            cnt      <= '0;
            dvd      <= '0;
            dvr      <= '0;
            sgn      <= 1'b0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            case (state)
                S_FREE: begin
                    if (start_i && !annul_i) begin
                        sgn    <= signed_div_i;
                        sign1  <= opdata1_i[WIDTH-1];
                        sign2  <= opdata2_i[WIDTH-1];
                        dvd    <= {{WIDTH{1'b0}}, abs1, 1'b0};
                        dvr    <= abs2;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= (opdata2_i == '0) ? S_BYZERO : S_ON;
                    end
                end
                S_BYZERO: begin
                    result_o <= '0;
                    busy_o   <= 1'b0;
                    if (annul_i) begin
                        cnt   <= '0;
                        state <= S_FREE;
                    end else begin
                        ready_o <= 1'b1;
                        state   <= S_END;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        cnt      <= '0;
                        result_o <= '0;
                        busy_o   <= 1'b0;
                        state    <= S_FREE;
                    end else if (cnt == CNT_W'(WIDTH)) begin
                        result_o <= {r_fix, q_fix};
                        cnt      <= '0;
                        busy_o   <= 1'b0;
                        ready_o  <= 1'b1;
                        state    <= S_END;
                    end else begin
                        if (diff[WIDTH])
                            dvd <= {dvd[2*WIDTH-1:0], 1'b0};
                        else
                            dvd <= {diff[WIDTH-1:0], dvd[WIDTH-1:0], 1'b1};
                        cnt <= cnt + 1'b1;
                    end
                end
                S_END: begin
                    if (!start_i || annul_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                        state    <= S_FREE;
                    end
                end
                default: state <= S_FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed and randomised bench for div_ctrl; expected results queued at start, checked at ready.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        Rst_n;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [63:0] sb[$];

    div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .Rst_n        (Rst_n),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: start at E0, wait for ready, check, hold start, then release.
    task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        int n;
        logic [63:0] want;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        sb.push_back(exp);
        tick();
        check({tag, "_busy0"}, 64'(busy_o), 64'd1);
        check({tag, "_res0"}, result_o, 64'd0);
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_div_i = ~s;
        n = 0;
        while (!ready_o && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        want = sb.pop_front();
        check({tag, "_res"}, result_o, want);
        check({tag, "_busyE"}, 64'(busy_o), 64'd0);
        tick();
        check({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
        check({tag, "_hold_res"}, result_o, want);
        start_i = 1'b0;
        tick();
        check({tag, "_free_rdy"}, 64'(ready_o), 64'd0);
        check({tag, "_free_res"}, result_o, 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic signed [31:0] sa, sbv, sq, sr;
        Rst_n = 1'b0; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        start_i = 1'b0; annul_i = 1'b0;
        #12;
        check("rst_res", result_o, 64'd0);
        check("rst_rdy", 64'(ready_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        Rst_n = 1'b1;
        tick();

        // T1..T4 directed cases
        run_div("divu_7_2", 1'b0, 32'd7, 32'd2, {32'h1, 32'h3}, 33);
        run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 33);
        run_div("divu_by0", 1'b0, 32'h1234, 32'd0, 64'd0, 1);
        run_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33);
        run_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 33);
        run_div("divu_big", 1'b0, 32'hFFFFFFF9, 32'd2, {32'h1, 32'h7FFFFFFC}, 33);

        // T5 annul mid-operation
        signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd3; start_i = 1'b1;
        tick();
        repeat (9) tick();
        annul_i = 1'b1; start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        check("annul_busy", 64'(busy_o), 64'd0);
        check("annul_res", result_o, 64'd0);
        for (int i = 0; i < 40; i++) begin
            if (ready_o) check("annul_rdy", 64'(ready_o), 64'd0);
            tick();
        end
        check("annul_rdy_end", 64'(ready_o), 64'd0);
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

        // T6 asynchronous reset mid-operation
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd9; start_i = 1'b1;
        repeat (20) tick();
        #2;
        Rst_n = 1'b0;
        #1;
        check("arst_res", result_o, 64'd0);
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_rdy", 64'(ready_o), 64'd0);
        start_i = 1'b0;
        tick();
        Rst_n = 1'b1;
        tick();
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        // Randomised operands against a behavioural model
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = 32'($urandom_range(1, 5000));
            if (i % 2 == 1) begin
                if (a == 32'h80000000) a = 32'd1;
                if ($urandom_range(0, 1) == 1) b = '0 - b;
                sa = $signed(a); sbv = $signed(b);
                sq = sa / sbv; sr = sa % sbv;
                run_div("rand_div", 1'b1, a, b, {sr, sq}, 33);
            end else begin
                run_div("rand_divu", 1'b0, a, b, {a % b, a / b}, 33);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
